// File: rtl/wb_interconnect_rr.sv
// Wishbone N-master x M-slave crossbar: per-slave round-robin arbitration with the grant
// locked for the whole bus cycle, an internal decode-error responder and a stall watchdog.
module wb_interconnect_rr #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int N_SLAVES       = 3,
  parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
  input  logic [N_MASTERS*3-1:0]                 m_cti,
  input  logic [N_MASTERS*2-1:0]                 m_bte,
  input  logic [N_MASTERS-1:0]                   m_cyc,
  input  logic [N_MASTERS-1:0]                   m_stb,
  input  logic [N_MASTERS-1:0]                   m_we,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_r,
  output logic [N_MASTERS-1:0]                   m_ack,
  output logic [N_MASTERS-1:0]                   m_err,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]      s_adr,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_w,
  output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]  s_sel,
  output logic [N_SLAVES*3-1:0]                  s_cti,
  output logic [N_SLAVES*2-1:0]                  s_bte,
  output logic [N_SLAVES-1:0]                    s_cyc,
  output logic [N_SLAVES-1:0]                    s_stb,
  output logic [N_SLAVES-1:0]                    s_we,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]      s_dat_r,
  input  logic [N_SLAVES-1:0]                    s_ack,
  input  logic [N_SLAVES-1:0]                    s_err
);

  localparam int AW  = WB_ADDR_WIDTH;
  localparam int DW  = WB_DATA_WIDTH;
  localparam int BW  = WB_DATA_WIDTH / 8;
  localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SIW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic WDT_ON = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [WDW-1:0] WDT_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OWN  = 2'd2,
    ST_DERR = 2'd3
  } mst_state_t;

  mst_state_t           r_state     [N_MASTERS];
  mst_state_t           w_state_nxt [N_MASTERS];
  logic [SIW-1:0]       r_tgt       [N_MASTERS];
  logic [SIW-1:0]       w_dec_idx   [N_MASTERS];
  logic [N_MASTERS-1:0] w_dec_hit;
  logic [N_MASTERS-1:0] r_derr_err;
  logic [N_MASTERS-1:0] w_derr_nxt;
  logic [N_MASTERS-1:0] w_granted;
  logic [N_MASTERS-1:0] w_timed_out;

  logic [N_MASTERS-1:0] w_req     [N_SLAVES];
  logic [N_SLAVES-1:0]  r_gnt_vld;
  logic [MIW-1:0]       r_gnt_own [N_SLAVES];
  logic [MIW-1:0]       r_ptr     [N_SLAVES];
  logic [MIW-1:0]       w_sel     [N_SLAVES];
  logic [N_SLAVES-1:0]  w_fire;
  logic [N_SLAVES-1:0]  w_free;
  logic [N_SLAVES-1:0]  w_own_stb;
  logic [N_SLAVES-1:0]  w_to;
  logic [WDW-1:0]       r_wdt     [N_SLAVES];

  // Address decode: scan from the highest slave down so the lowest matching index wins.
  function automatic logic [SIW:0] f_decode(input logic [AW-1:0] adr);
    logic [SIW:0] res;
    res = '0;
    for (int j = N_SLAVES - 1; j >= 0; j--) begin
      if ((adr >= ADDR_RANGES[(2*(N_SLAVES-j)-1)*AW +: AW]) &&
          (adr <= ADDR_RANGES[(2*(N_SLAVES-j)-2)*AW +: AW])) begin
        res = {1'b1, SIW'(j)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  always_comb begin
    logic [SIW:0] dec;
    dec = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      dec          = f_decode(m_adr[i*AW +: AW]);
      w_dec_hit[i] = dec[SIW];
      w_dec_idx[i] = dec[SIW-1:0];
    end
  end

  // Fresh requests use the live decode; waiting masters use their latched target.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        w_req[j][i] = m_cyc[i] &&
                      (((r_state[i] == ST_IDLE) && m_stb[i] && w_dec_hit[i] &&
                        (w_dec_idx[i] == SIW'(j))) ||
                       ((r_state[i] == ST_WAIT) && (r_tgt[i] == SIW'(j))));
      end
    end
  end

  always_comb begin
    int o;
    o = 0;
    for (int j = 0; j < N_SLAVES; j++) begin
      o            = int'(r_gnt_own[j]);
      w_own_stb[j] = r_gnt_vld[j] & m_cyc[o] & m_stb[o];
      w_to[j]      = WDT_ON & w_own_stb[j] & ~s_ack[j] & ~s_err[j] & (r_wdt[j] == WDT_LAST);
    end
  end

  // Round-robin pick starting at the pointer; only takes effect while the slave is free.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int j = 0; j < N_SLAVES; j++) begin
      found     = 1'b0;
      w_sel[j]  = '0;
      w_free[j] = !r_gnt_vld[j] || !m_cyc[r_gnt_own[j]] || w_to[j];
      for (int k = 0; k < N_MASTERS; k++) begin
        idx = int'(r_ptr[j]) + k;
        if (idx >= N_MASTERS) begin
          idx = idx - N_MASTERS;
        end else begin
          idx = idx;
        end
        if (!found && w_req[j][idx]) begin
          found    = 1'b1;
          w_sel[j] = MIW'(idx);
        end else begin
          found = found;
        end
      end
      w_fire[j] = found & w_free[j];
    end
  end

  always_comb begin
    w_granted   = '0;
    w_timed_out = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        w_granted[i]   = w_granted[i] | (w_fire[j] & (w_sel[j] == MIW'(i)));
        w_timed_out[i] = w_timed_out[i] |
                         (w_to[j] & r_gnt_vld[j] & (r_gnt_own[j] == MIW'(i)));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_derr_nxt[i]  = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          if (m_cyc[i] && m_stb[i]) begin
            if (!w_dec_hit[i]) begin
              w_state_nxt[i] = ST_DERR;
              w_derr_nxt[i]  = 1'b1;
            end else if (w_granted[i]) begin
              w_state_nxt[i] = ST_OWN;
            end else begin
              w_state_nxt[i] = ST_WAIT;
            end
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!m_cyc[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else if (w_granted[i]) begin
            w_state_nxt[i] = ST_OWN;
          end else begin
            w_state_nxt[i] = ST_WAIT;
          end
        end
        ST_OWN: begin
          if (!m_cyc[i] || w_timed_out[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else begin
            w_state_nxt[i] = ST_OWN;
          end
        end
        ST_DERR: begin
          if (!m_cyc[i]) begin
            w_state_nxt[i] = ST_IDLE;
          end else begin
            w_state_nxt[i] = ST_DERR;
            // One registered error per beat; the error cycle itself closes the beat.
            w_derr_nxt[i]  = m_stb[i] & ~r_derr_err[i];
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        r_state[i] <= ST_IDLE;
        r_tgt[i]   <= '0;
      end
      r_derr_err <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if ((r_state[i] == ST_IDLE) && m_cyc[i] && m_stb[i]) begin
          r_tgt[i] <= w_dec_idx[i];
        end
      end
      r_derr_err <= w_derr_nxt;
    end
  end

  // Grant, pointer and watchdog registers per slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_vld <= '0;
      for (int j = 0; j < N_SLAVES; j++) begin
        r_gnt_own[j] <= '0;
        r_ptr[j]     <= '0;
        r_wdt[j]     <= '0;
      end
    end else begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (w_free[j]) begin
          r_gnt_vld[j] <= w_fire[j];
          if (w_fire[j]) begin
            r_gnt_own[j] <= w_sel[j];
            r_ptr[j]     <= (w_sel[j] == MIW'(N_MASTERS - 1)) ? '0 : w_sel[j] + 1'b1;
          end
        end
        if (w_free[j] || s_ack[j] || s_err[j]) begin
          r_wdt[j] <= '0;
        end else if (w_own_stb[j]) begin
          r_wdt[j] <= r_wdt[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    int o;
    o       = 0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      o = int'(r_gnt_own[j]);
      if (r_gnt_vld[j] && m_cyc[o] && !w_to[j]) begin
        s_cyc[j]             = 1'b1;
        s_stb[j]             = m_stb[o];
        s_we[j]              = m_we[o];
        s_adr[j*AW +: AW]    = m_adr[o*AW +: AW];
        s_dat_w[j*DW +: DW]  = m_dat_w[o*DW +: DW];
        s_sel[j*BW +: BW]    = m_sel[o*BW +: BW];
        s_cti[j*3 +: 3]      = m_cti[o*3 +: 3];
        s_bte[j*2 +: 2]      = m_bte[o*2 +: 2];
      end else begin
        s_cyc[j] = 1'b0;
      end
    end
  end

  // Responses reach the owning master only; everyone else sees a stalled bus.
  always_comb begin
    m_dat_r = '0;
    m_ack   = '0;
    m_err   = r_derr_err;
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (r_gnt_vld[j] && (r_gnt_own[j] == MIW'(i))) begin
          m_ack[i]            = s_ack[j];
          m_err[i]            = s_err[j] | w_to[j];
          m_dat_r[i*DW +: DW] = s_dat_r[j*DW +: DW];
        end else begin
          m_ack[i] = m_ack[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect_rr.sv
// Directed bench for wb_interconnect_rr: 4 masters, 3 slaves (0x0000/0x1000/0x2000 4 KiB
// windows), watchdog of 8 cycles; slaves answer one cycle after each strobe.
module tb_wb_interconnect_rr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 4;
  localparam int NS = 3;
  localparam logic [2*NS*AW-1:0] RANGES = {32'h0000_0000, 32'h0000_0FFF,
                                           32'h0000_1000, 32'h0000_1FFF,
                                           32'h0000_2000, 32'h0000_2FFF};

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_w;
  logic [NM*4-1:0]   m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*DW-1:0]  m_dat_r;
  logic [NM-1:0]     m_ack, m_err;
  logic [NS*AW-1:0]  s_adr;
  logic [NS*DW-1:0]  s_dat_w;
  logic [NS*4-1:0]   s_sel;
  logic [NS*3-1:0]   s_cti;
  logic [NS*2-1:0]   s_bte;
  logic [NS-1:0]     s_cyc, s_stb, s_we;
  logic [NS*DW-1:0]  s_dat_r;
  logic [NS-1:0]     s_ack, s_err;

  logic [NS-1:0]     r_sack;
  logic [NS-1:0]     s_en;
  logic              force_ack2;
  int                n_cmp = 0;
  int                n_bad = 0;

  wb_interconnect_rr #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_MASTERS(NM), .N_SLAVES(NS),
    .ADDR_RANGES(RANGES), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
  );

  always #5 clk = ~clk;

  assign s_dat_r = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
  assign s_ack   = r_sack | {force_ack2, 2'b00};
  assign s_err   = 3'b000;

  always @(posedge clk or posedge rst) begin
    if (rst) r_sack <= 3'b000;
    else     r_sack <= s_cyc & s_stb & ~r_sack & s_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr);
    m_cyc[i]           = cyc;
    m_stb[i]           = stb;
    m_we[i]            = we;
    m_adr[i*AW +: AW]  = adr;
  endtask

  // All four masters burst 4 beats to slave 1; owner is inferred from the routed address.
  task automatic burst_round(input string tag);
    int   beats[NM];
    int   order[$];
    int   last;
    int   owner;
    logic done;
    last = -1;
    done = 1'b0;
    for (int i = 0; i < NM; i++) begin
      beats[i] = 0;
      set_m(i, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 16));
    end
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) if (m_ack[i]) beats[i]++;
      if (s_cyc[1] && s_stb[1]) begin
        owner = int'((s_adr[AW +: AW] - 32'h1000) >> 4);
        if (owner != last) begin
          order.push_back(owner);
          last = owner;
        end
      end
      tick();
      done = 1'b1;
      for (int i = 0; i < NM; i++) begin
        if (beats[i] >= 4) set_m(i, 1'b0, 1'b0, 1'b0, 32'h0);
        else done = 1'b0;
      end
    end
    chk({tag, "_owner_runs"}, 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_order%0d", tag, k), (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(k));
    for (int i = 0; i < NM; i++)
      chk($sformatf("%s_beats_m%0d", tag, i), 32'(beats[i]), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic got;
    rst        = 1'b1;
    m_adr      = '0;
    m_dat_w    = {NM{32'hA5A5_0000}};
    m_sel      = '1;
    m_cti      = '0;
    m_bte      = '0;
    m_cyc      = '0;
    m_stb      = '0;
    m_we       = '0;
    s_en       = 3'b111;
    force_ack2 = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single read from slave 0: s_cyc at t+1, ack with data at t+2.
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h100);
    @(negedge clk); chk("rd_t0_s0cyc", 32'(s_cyc), 32'd0);
    tick(); @(negedge clk);
    chk("rd_t1_s0cyc", 32'(s_cyc), 32'd1);
    chk("rd_t1_adr", s_adr[31:0], 32'h100);
    chk("rd_t1_ack", 32'(m_ack), 32'd0);
    tick(); @(negedge clk);
    chk("rd_t2_ack", 32'(m_ack), 32'd1);
    chk("rd_t2_data", m_dat_r[31:0], 32'hDEAD_BEEF);
    tick(); set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("rd_end_s0cyc", 32'(s_cyc), 32'd0);
    tick(); tick();

    burst_round("rr1");
    tick();
    burst_round("rr2");
    tick(); tick();

    // Two masters to two different slaves in the same cycle.
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h200);
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h2000);
    @(negedge clk); chk("cc_t0_cyc", 32'(s_cyc), 32'd0);
    tick(); @(negedge clk); chk("cc_t1_cyc", 32'(s_cyc), 32'b101);
    tick(); @(negedge clk);
    chk("cc_t2_ack", 32'(m_ack), 32'b0101);
    chk("cc_t2_d0", m_dat_r[0 +: 32], 32'hDEAD_BEEF);
    chk("cc_t2_d2", m_dat_r[64 +: 32], 32'h2222_2222);
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Unmapped write: error one cycle after each strobe beat, no slave touched.
    set_m(1, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000);
    @(negedge clk); chk("de_t0_err", 32'(m_err), 32'd0); chk("de_t0_scyc", 32'(s_cyc), 32'd0);
    tick(); @(negedge clk); chk("de_t1_err", 32'(m_err), 32'b0010); chk("de_t1_scyc", 32'(s_cyc), 32'd0);
    tick(); m_stb[1] = 1'b0; @(negedge clk); chk("de_t2_err", 32'(m_err), 32'd0);
    tick(); m_stb[1] = 1'b1; @(negedge clk); chk("de_t3_err", 32'(m_err), 32'd0);
    tick(); @(negedge clk); chk("de_t4_err", 32'(m_err), 32'b0010);
    tick(); set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("de_t5_err", 32'(m_err), 32'd0); chk("de_t5_scyc", 32'(s_cyc), 32'd0);
    tick(); tick();

    // Watchdog: slave 2 silent, error expected on the 8th stalled cycle.
    s_en[2] = 1'b0;
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h2000);
    cnt = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick(); @(negedge clk);
      if (c == 7) chk("wd_c7_scyc", 32'(s_cyc[2]), 32'd1);
      if (m_err[3]) begin
        got = 1'b1;
        cnt = c;
        chk("wd_err_scyc", 32'(s_cyc[2]), 32'd0);
      end
    end
    chk("wd_cycles", 32'(cnt), 32'd8);
    tick(); set_m(3, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("wd_after_err", 32'(m_err), 32'd0); chk("wd_after_scyc", 32'(s_cyc), 32'd0);
    tick(); tick();

    // Same stall, but the slave acks in the would-be timeout cycle.
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h2000);
    repeat (8) tick();
    force_ack2 = 1'b1;
    @(negedge clk);
    chk("wd2_ack", 32'(m_ack[3]), 32'd1);
    chk("wd2_err", 32'(m_err[3]), 32'd0);
    chk("wd2_scyc", 32'(s_cyc[2]), 32'd1);
    tick(); force_ack2 = 1'b0; set_m(3, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    s_en[2] = 1'b1;

    // Address moves into slave 1's window mid-cycle; routing stays on slave 0.
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h300);
    tick(); m_adr[31:0] = 32'h1500;
    @(negedge clk);
    chk("gl_t1_s0cyc", 32'(s_cyc[0]), 32'd1);
    chk("gl_t1_s1cyc", 32'(s_cyc[1]), 32'd0);
    chk("gl_t1_adr", s_adr[31:0], 32'h1500);
    tick(); @(negedge clk);
    chk("gl_t2_ack", 32'(m_ack), 32'd1);
    chk("gl_t2_s1cyc", 32'(s_cyc[1]), 32'd0);
    tick(); set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Asynchronous reset in the middle of a granted cycle.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h400);
    tick();
    #2;
    chk("mr_pre_scyc", 32'(s_cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_s_cyc", 32'(s_cyc), 32'd0);
    chk("mr_s_stb", 32'(s_stb), 32'd0);
    chk("mr_m_ack", 32'(m_ack), 32'd0);
    chk("mr_m_err", 32'(m_err), 32'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); rst = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
